seq_detect_prog: RTL and testbench
==================================

Name: seq_detect_prog

Overview:
- Runtime-programmable serial sequence detector, successor to the fixed-pattern 1011 detector.
- Pattern length (1..MAX_LEN) and pattern bits are loaded at run time.
- Overlapping or non-overlapping detection is selected by a mode input.
- Sits on a serial bit stream with a valid qualifier; produces a one-cycle match pulse and, optionally, a saturating match count.

Parameters:
- MAX_LEN, 8, maximum pattern length in bits (>=2).
- LEN_W, 4, width of the cfg_len field; must satisfy 2^LEN_W > MAX_LEN.
- CNT_W, 16, width of match_count (used only with the optional feature).

Ports:
- clk  input  1  single clock, all state updates on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- cfg_load  input  1  load cfg_pattern/cfg_len/cfg_overlap this cycle.
- cfg_pattern  input  MAX_LEN  pattern; bit [len-1] is the first bit expected on the wire, bit [0] the last.
- cfg_len  input  LEN_W  pattern length.
- cfg_overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
- inp_valid  input  1  inp_bit is sampled only when high.
- inp_bit  input  1  serial data bit.
- seq_seen  output  1  one-cycle match pulse.
- busy  output  1  high while the history holds at least one valid bit since the last load/clear.
- match_count  output  CNT_W  saturating match count (present only when SEQ_DET_COUNT_EN is defined).

Behaviour:
- Async reset (reset_n=0):
  - history=0, fill=0, seq_seen=0, busy=0, match_count=0.
  - Stored pattern = all ones (MAX_LEN bits), len=MAX_LEN, overlap=1.
- Configuration:
  - On a clk edge with cfg_load=1, latch pattern, len and overlap; clear history and fill.
  - cfg_len=0 or cfg_len>MAX_LEN is clamped to MAX_LEN.
  - cfg_load has priority: inp_bit is ignored that cycle, seq_seen=0 next cycle, match_count is unchanged.
- Data path:
  - On a clk edge with inp_valid=1 and cfg_load=0, shift history left, with inp_bit entering bit 0.
  - fill increments, saturating at MAX_LEN.
  - inp_valid=0: history, fill and the count hold; seq_seen is 0 next cycle.
- Match condition, evaluated on the new bit combinationally: fill_next >= len and history_next[len-1:0] == pattern[len-1:0].
- seq_seen is registered:
  - Asserted in the cycle after the edge that sampled the final pattern bit; one-cycle latency, matching the predecessor's state-register timing.
  - High for exactly one cycle per match.
- Overlap mode 1: history and fill are kept after a match, so a suffix of the match can start the next one. Example: 1011 on stream 1011011 gives 2 matches.
- Overlap mode 0: on a match, fill is cleared to 0, so the next match needs len fresh bits. Example: 1011 on stream 1011011 gives 1 match.
- busy = (fill != 0), registered.
- A mid-stream reset or cfg_load discards partial matches; there is no spurious seq_seen.
- Pattern length 1: every valid bit equal to pattern[0] produces a pulse.
- Back-to-back matches on consecutive valid cycles produce consecutive seq_seen pulses. Example: len=1, or pattern 11 on a run of ones in overlap mode.

Optional Feature:
- Macro: SEQ_DET_COUNT_EN.
- Defined:
  - match_count port exists.
  - Increments by 1 on each cycle where seq_seen is set.
  - Saturates at 2^CNT_W-1.
  - Cleared by reset and by cfg_load.
- Undefined: port and counter logic are absent; all other behaviour is identical.

Test Plan:
- Reset then load pattern=8'b00001011, len=4, overlap=1; stream 1,0,1,1,0,1,1 all valid -> seq_seen pulses in the cycles after bits 4 and 7; match_count=2.
- Same stream with overlap=0 -> single pulse after bit 4; match_count=1.
- Load len=4 pattern 1011; stream 1,0,1 with inp_valid low for 3 cycles, then 1 -> no pulse during the gap; pulse one cycle after the final bit.
- Stream 1,0,1, then cfg_load asserted together with inp_valid=1, inp_bit=1 -> no pulse; busy=0, match_count=0 after load.
- Load cfg_len=0 with pattern 8'hFF, then 8 ones -> first pulse only after the 8th one (clamped to MAX_LEN); a 9th one gives a second pulse (overlap=1).
- Build with SEQ_DET_COUNT_EN and CNT_W=2; len=1, pattern 1; feed 5 ones -> match_count reaches 3 and holds; assert reset_n=0 mid-stream -> all outputs 0 immediately (asynchronous).

Source files
------------

// File: rtl/seq_detect_prog_if.sv
// Bundle of configuration, serial-input and result signals for seq_detect_prog.
// The master side drives configuration and the bit stream. The slave side is the detector.
// The match_count signal exists only when SEQ_DET_COUNT_EN is defined.
interface seq_detect_prog_if #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4,
  parameter int CNT_W   = 16
);

  logic               cfg_load;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               inp_valid;
  logic               inp_bit;
  logic               seq_seen;
  logic               busy;
`ifdef SEQ_DET_COUNT_EN
  logic [CNT_W-1:0]   match_count;
`endif

  // An empty marker scope that appears only for nonsensical counter widths.
  if (CNT_W < 1) begin : g_bad_cnt_w
  end

  modport master (
    output cfg_load, cfg_pattern, cfg_len, cfg_overlap, inp_valid, inp_bit,
    input  seq_seen, busy
`ifdef SEQ_DET_COUNT_EN
    , input match_count
`endif
  );

  modport slave (
    input  cfg_load, cfg_pattern, cfg_len, cfg_overlap, inp_valid, inp_bit,
    output seq_seen, busy
`ifdef SEQ_DET_COUNT_EN
    , output match_count
`endif
  );

endinterface

// File: rtl/seq_detect_prog.sv
// Runtime-programmable serial sequence detector.
// Pattern bits, length (1..MAX_LEN) and overlap mode are loaded through cfg_load.
// A registered one-cycle seq_seen pulse follows the edge that sampled the last pattern bit.
// Optional feature macro: SEQ_DET_COUNT_EN adds a saturating match_count.
module seq_detect_prog #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4,
  parameter int CNT_W   = 16
) (
  input logic                clk,
  input logic                reset_n,
  seq_detect_prog_if.slave   bus
);

  // An empty marker scope that appears only when cfg_len cannot encode MAX_LEN.
  if ((MAX_LEN < 2) || ((1 << LEN_W) <= MAX_LEN) || (CNT_W < 1)) begin : g_bad_params
  end

  localparam logic [LEN_W-1:0] LP_MAX_LEN = LEN_W'(MAX_LEN);

  logic [MAX_LEN-1:0] r_pattern;
  logic [LEN_W-1:0]   r_len;
  logic               r_overlap;
  logic [MAX_LEN-2:0] r_hist;
  logic [LEN_W-1:0]   r_fill;
  logic               r_seen;
  logic               r_busy;

  logic [LEN_W-1:0]   w_len_clamped;
  logic [MAX_LEN-1:0] w_hist_next;
  logic [LEN_W-1:0]   w_fill_next;
  logic [LEN_W-1:0]   w_fill_after;
  logic [MAX_LEN-1:0] w_mask;
  logic               w_match;

  // Evaluate the incoming bit against the stored pattern. The top history bit is never kept because only MAX_LEN bits can ever be compared.
  always_comb begin
    w_len_clamped = bus.cfg_len;
    if ((bus.cfg_len == '0) || (bus.cfg_len > LP_MAX_LEN)) begin
      w_len_clamped = LP_MAX_LEN;
    end
    w_hist_next = {r_hist, bus.inp_bit};
    w_fill_next = (r_fill == LP_MAX_LEN) ? r_fill : r_fill + LEN_W'(1);
    w_mask      = ~({MAX_LEN{1'b1}} << r_len);
    w_match     = (w_fill_next >= r_len) &&
                  ((w_hist_next & w_mask) == (r_pattern & w_mask));
    w_fill_after = (w_match && !r_overlap) ? '0 : w_fill_next;
  end

  // Configuration, history shifting, fill tracking and the registered match/busy outputs. A load wins over a valid bit in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pattern <= '1;
      r_len     <= LP_MAX_LEN;
      r_overlap <= 1'b1;
      r_hist    <= '0;
      r_fill    <= '0;
      r_seen    <= 1'b0;
      r_busy    <= 1'b0;
    end else if (bus.cfg_load) begin
      r_pattern <= bus.cfg_pattern;
      r_len     <= w_len_clamped;
      r_overlap <= bus.cfg_overlap;
      r_hist    <= '0;
      r_fill    <= '0;
      r_seen    <= 1'b0;
      r_busy    <= 1'b0;
    end else if (bus.inp_valid) begin
      r_hist    <= w_hist_next[MAX_LEN-2:0];
      r_fill    <= w_fill_after;
      r_seen    <= w_match;
      r_busy    <= (w_fill_after != '0);
    end else begin
      r_seen    <= 1'b0;
    end
  end

  assign bus.seq_seen = r_seen;
  assign bus.busy     = r_busy;

`ifdef SEQ_DET_COUNT_EN
  logic [CNT_W-1:0] r_count;

  // Count matches on the same edge that raises seq_seen. Hold at all-ones and restart on a load.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (bus.cfg_load) begin
      r_count <= '0;
    end else if (bus.inp_valid && w_match && (r_count != '1)) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign bus.match_count = r_count;
`endif

endmodule

// File: tb/tb_seq_detect_prog.sv
// Self-checking bench for seq_detect_prog.
// A bit-list reference model is driven by directed scenarios and then a randomized run.
// It also covers the SEQ_DET_COUNT_EN build, with a 2-bit counter so that saturation is reachable.
module tb_seq_detect_prog;

  localparam int MAX_LEN = 8;
  localparam int LEN_W   = 4;
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  int compared = 0;
  int mismatched = 0;

  // Reference model state. It holds the list of bits received since the last load, plus the number of fresh bits since the last load or non-overlap match.
  logic [MAX_LEN-1:0] mPat;
  int                 mLen;
  bit                 mOv;
  bit                 mHist[$];
  int                 mFresh;
  bit                 expSeen;
  int                 expCount;

  seq_detect_prog_if #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W)) bus ();

  seq_detect_prog #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Free-running clock with a 10 time-unit period.
  always #5 clk = ~clk;

  task automatic modelReset();
    mPat = '1;
    mLen = MAX_LEN;
    mOv = 1'b1;
    mHist.delete();
    mFresh = 0;
    expSeen = 1'b0;
    expCount = 0;
  endtask

  task automatic checkOutput(input string tag);
    compared++;
    assert (bus.seq_seen === expSeen) else begin
      mismatched++;
      $error("[TB] FAIL %s seq_seen observed=%0b expected=%0b", tag, bus.seq_seen, expSeen);
    end
    compared++;
    assert (bus.busy === (mFresh != 0)) else begin
      mismatched++;
      $error("[TB] FAIL %s busy observed=%0b expected=%0b", tag, bus.busy, (mFresh != 0));
    end
`ifdef SEQ_DET_COUNT_EN
    compared++;
    assert (bus.match_count === CNT_W'(expCount)) else begin
      mismatched++;
      $error("[TB] FAIL %s match_count observed=%0d expected=%0d", tag, bus.match_count, expCount);
    end
`endif
  endtask

  // Drive one cycle of inputs, let the DUT see one edge, advance the model, then compare.
  task automatic applyStimulus(input string tag, input bit load, input logic [MAX_LEN-1:0] pat,
                               input int len, input bit ov, input bit valid, input bit b);
    bit match;
    bus.cfg_load    = load;
    bus.cfg_pattern = pat;
    bus.cfg_len     = LEN_W'(len);
    bus.cfg_overlap = ov;
    bus.inp_valid   = valid;
    bus.inp_bit     = b;
    @(posedge clk);
    #1;
    if (load) begin
      mPat = pat;
      mLen = ((len == 0) || (len > MAX_LEN)) ? MAX_LEN : len;
      mOv = ov;
      mHist.delete();
      mFresh = 0;
      expSeen = 1'b0;
      expCount = 0;
    end else if (valid) begin
      mHist.push_back(b);
      if (mHist.size() > 64) void'(mHist.pop_front());
      mFresh++;
      match = (mFresh >= mLen);
      if (match) begin
        for (int k = 0; k < mLen; k++) begin
          if (mHist[mHist.size() - 1 - k] != mPat[k]) match = 1'b0;
        end
      end
      expSeen = match;
      if (match) begin
        if (expCount < CNT_MAX) expCount++;
        if (!mOv) mFresh = 0;
      end
    end else begin
      expSeen = 1'b0;
    end
    bus.cfg_load  = 1'b0;
    bus.inp_valid = 1'b0;
    checkOutput(tag);
  endtask

  initial begin
    bit stream7[7];
    bit seen;
    bus.cfg_load    = 1'b0;
    bus.cfg_pattern = '0;
    bus.cfg_len     = '0;
    bus.cfg_overlap = 1'b0;
    bus.inp_valid   = 1'b0;
    bus.inp_bit     = 1'b0;
    stream7 = '{1, 0, 1, 1, 0, 1, 1};
    modelReset();

    #1;
    checkOutput("reset");
    @(negedge clk);
    reset_n = 1'b1;

    // Overlapping 1011 on stream 1011011: pulses after bits 4 and 7.
    applyStimulus("ov_load", 1, 8'b00001011, 4, 1, 0, 0);
    foreach (stream7[i]) applyStimulus("ov_stream", 0, '0, 0, 0, 1, stream7[i]);

    // Non-overlapping detection on the same stream: a single pulse.
    applyStimulus("nov_load", 1, 8'b00001011, 4, 0, 0, 0);
    foreach (stream7[i]) applyStimulus("nov_stream", 0, '0, 0, 0, 1, stream7[i]);

    // A gap in inp_valid holds the partial match.
    applyStimulus("gap_load", 1, 8'b00001011, 4, 1, 0, 0);
    applyStimulus("gap_b1", 0, '0, 0, 0, 1, 1);
    applyStimulus("gap_b2", 0, '0, 0, 0, 1, 0);
    applyStimulus("gap_b3", 0, '0, 0, 0, 1, 1);
    for (int i = 0; i < 3; i++) applyStimulus("gap_idle", 0, '0, 0, 0, 0, 1);
    applyStimulus("gap_b4", 0, '0, 0, 0, 1, 1);
    applyStimulus("gap_after", 0, '0, 0, 0, 0, 0);

    // A load that coincides with a completing bit discards the partial match.
    applyStimulus("ld_b1", 0, '0, 0, 0, 1, 1);
    applyStimulus("ld_b2", 0, '0, 0, 0, 1, 0);
    applyStimulus("ld_b3", 0, '0, 0, 0, 1, 1);
    applyStimulus("ld_collide", 1, 8'b00001011, 4, 1, 1, 1);

    // A length of zero clamps to MAX_LEN.
    applyStimulus("clamp_load", 1, 8'hFF, 0, 1, 0, 0);
    for (int i = 0; i < 9; i++) applyStimulus("clamp_ones", 0, '0, 0, 0, 1, 1);

    // Length one produces back-to-back pulses. The count saturates when enabled.
    applyStimulus("len1_load", 1, 8'h01, 1, 1, 0, 0);
    for (int i = 0; i < 5; i++) applyStimulus("len1_ones", 0, '0, 0, 0, 1, 1);

    // An asynchronous reset applied mid-cycle clears the outputs before the next edge.
    #2;
    reset_n = 1'b0;
    modelReset();
    #1;
    checkOutput("async_reset");
    @(negedge clk);
    reset_n = 1'b1;
    applyStimulus("post_reset_idle", 0, '0, 0, 0, 0, 0);

    // Randomized traffic with occasional reconfiguration, biased toward short patterns so matches happen often.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        applyStimulus("rnd_load", 1, MAX_LEN'($urandom),
                      ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(1, 4),
                      $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
      end else begin
        applyStimulus("rnd_data", 0, '0, 0, 0, ($urandom_range(0, 3) != 0), $urandom_range(0, 1));
      end
    end

    // Pattern 11 on a run of ones in overlap mode pulses on every valid bit after the first.
    applyStimulus("run11_load", 1, 8'b00000011, 2, 1, 0, 0);
    seen = 1'b0;
    for (int i = 0; i < 4; i++) applyStimulus("run11", 0, '0, 0, 0, 1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
